// File: rtl/matrix_pkg.sv
// Shared FSM state type and phase-length constants for the LED matrix scan driver.
package matrix_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        ROWCLK  = 3'd3,
        LATCH   = 3'd4,
        DISPLAY = 3'd5
    } state_t;

    // Phase lengths expressed in shift-clock half-periods (CLKDIV cycles each).
    localparam int SHIFT_HALVES_PER_COL = 32'd2;
    localparam int ROWCLK_HALVES        = 32'd2;
    localparam int LATCH_HALVES         = 32'd1;

endpackage

// File: rtl/matrix_col_shifter.sv
// Column serialiser: captures one framebuffer row and emits it MSB first on
// csdi, with cclk low for CLKDIV cycles then high for CLKDIV cycles per bit.
// shift_last flags the final cycle of the final high half-period.
module matrix_col_shifter
    import matrix_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int CLKDIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [COLS-1:0] data,
    output logic            csdi,
    output logic            cclk,
    output logic            shift_last
);

    localparam int HALVES = SHIFT_HALVES_PER_COL * COLS;
    localparam int HW     = $clog2(HALVES);
    localparam int DW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [COLS-1:0] shreg_r;
    logic [HW-1:0]   half_r;
    logic [DW-1:0]   div_r;
    logic            busy_r;
    logic            csdi_r;
    logic            cclk_r;
    logic            half_end_s;

    assign half_end_s = (div_r == DW'(CLKDIV - 1));
    assign shift_last = busy_r && half_end_s && (half_r == HW'(HALVES - 1));
    assign csdi       = csdi_r;
    assign cclk       = cclk_r;

    // Load, pace and serialise one row; clr returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= '0;
            half_r  <= '0;
            div_r   <= '0;
            busy_r  <= 1'b0;
            csdi_r  <= 1'b0;
            cclk_r  <= 1'b0;
        end else if (clr) begin
            shreg_r <= '0;
            half_r  <= '0;
            div_r   <= '0;
            busy_r  <= 1'b0;
            csdi_r  <= 1'b0;
            cclk_r  <= 1'b0;
        end else if (load) begin
            shreg_r <= data;
            half_r  <= '0;
            div_r   <= '0;
            busy_r  <= 1'b1;
            csdi_r  <= data[COLS-1];
            cclk_r  <= 1'b0;
        end else if (busy_r) begin
            if (half_end_s) begin
                div_r <= '0;
                if (half_r == HW'(HALVES - 1)) begin
                    busy_r <= 1'b0;
                    half_r <= '0;
                    csdi_r <= 1'b0;
                    cclk_r <= 1'b0;
                end else if (cclk_r) begin
                    // Falling edge of cclk: present the next bit.
                    half_r  <= half_r + HW'(1);
                    shreg_r <= {shreg_r[COLS-2:0], 1'b0};
                    csdi_r  <= shreg_r[COLS-2];
                    cclk_r  <= 1'b0;
                end else begin
                    half_r <= half_r + HW'(1);
                    cclk_r <= 1'b1;
                end
            end else begin
                div_r <= div_r + DW'(1);
            end
        end else begin
            div_r <= div_r;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// LED matrix scan driver: holds a ROWS x COLS framebuffer and scans it one row
// at a time (load, shift columns, clock row select, latch, display).
// Optional build macro MATRIX_BRIGHTNESS_EN adds a 4-bit brightness input that
// shortens the OEB-low portion of each DISPLAY phase in 1/16 steps.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int CLKDIV   = 4,
    parameter int ROW_HOLD = 256
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     active,
    input  logic                     fb_we,
    input  logic [$clog2(ROWS)-1:0]  fb_row,
    input  logic [COLS-1:0]          fb_data,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [3:0]               brightness,
`endif
    output logic                     CSDI,
    output logic                     CCLK,
    output logic                     LE,
    output logic                     RSDI,
    output logic                     RCLK,
    output logic                     OEB,
    output logic                     frame_start
);

    localparam int RW         = $clog2(ROWS);
    localparam int ROWCLK_LEN = ROWCLK_HALVES * CLKDIV;
    localparam int LATCH_LEN  = LATCH_HALVES * CLKDIV;
    localparam int CNT_MAX    = (ROW_HOLD > ROWCLK_LEN) ? ROW_HOLD : ROWCLK_LEN;
    localparam int CW         = $clog2(CNT_MAX + 1);

    logic [COLS-1:0] fb_r [ROWS];
    state_t          state_r;
    logic [RW-1:0]   row_r;
    logic [CW-1:0]   cnt_r;
    logic            le_r;
    logic            rsdi_r;
    logic            rclk_r;
    logic            oeb_r;
    logic            frame_start_r;
    logic            fb_row_ok_s;
    logic [COLS-1:0] load_data_s;
    logic            shift_last_s;

`ifdef MATRIX_BRIGHTNESS_EN
    logic [3:0]      bright_r;
    logic [CW-1:0]   on_len_s;
    assign on_len_s = CW'((32'(bright_r) + 32'd1) * (ROW_HOLD / 32'd16));
`endif

    assign fb_row_ok_s = ({1'b0, fb_row} < (RW + 1)'(ROWS));

    // Row captured at LOAD; a same-cycle write to that row wins (write-first).
    always_comb begin
        load_data_s = fb_r[row_r];
        if (fb_we && fb_row_ok_s && (fb_row == row_r)) begin
            load_data_s = fb_data;
        end else begin
            load_data_s = fb_r[row_r];
        end
    end

    // Framebuffer storage; cleared only by reset, kept across active drops.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < ROWS; i++) begin
                fb_r[i] <= '0;
            end
        end else if (fb_we && fb_row_ok_s) begin
            fb_r[fb_row] <= fb_data;
        end else begin
            fb_r <= fb_r;
        end
    end

    matrix_col_shifter #(
        .COLS   (COLS),
        .CLKDIV (CLKDIV)
    ) u_col_shifter (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .clr        (~active),
        .load       (state_r == LOAD),
        .data       (load_data_s),
        .csdi       (CSDI),
        .cclk       (CCLK),
        .shift_last (shift_last_s)
    );

    // Scan sequencer with registered row/latch/enable outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r       <= IDLE;
            row_r         <= '0;
            cnt_r         <= '0;
            le_r          <= 1'b0;
            rsdi_r        <= 1'b0;
            rclk_r        <= 1'b0;
            oeb_r         <= 1'b1;
            frame_start_r <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
            bright_r      <= 4'd0;
`endif
        end else if (!active) begin
            state_r       <= IDLE;
            row_r         <= '0;
            cnt_r         <= '0;
            le_r          <= 1'b0;
            rsdi_r        <= 1'b0;
            rclk_r        <= 1'b0;
            oeb_r         <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= LOAD;
                    cnt_r   <= '0;
                end
                LOAD: begin
                    state_r       <= SHIFT;
                    frame_start_r <= (row_r == '0);
                end
                SHIFT: begin
                    if (shift_last_s) begin
                        state_r <= ROWCLK;
                        cnt_r   <= '0;
                        rsdi_r  <= (row_r == '0);
                        rclk_r  <= 1'b0;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                ROWCLK: begin
                    if (cnt_r == CW'(ROWCLK_LEN - 1)) begin
                        state_r <= LATCH;
                        cnt_r   <= '0;
                        rclk_r  <= 1'b0;
                        rsdi_r  <= 1'b0;
                        le_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(CLKDIV - 1)) begin
                            rclk_r <= 1'b1;
                        end else begin
                            rclk_r <= rclk_r;
                        end
                    end
                end
                LATCH: begin
                    if (cnt_r == CW'(LATCH_LEN - 1)) begin
                        state_r <= DISPLAY;
                        cnt_r   <= '0;
                        le_r    <= 1'b0;
                        oeb_r   <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
                        bright_r <= brightness;
`endif
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DISPLAY: begin
                    if (cnt_r == CW'(ROW_HOLD - 1)) begin
                        state_r <= LOAD;
                        cnt_r   <= '0;
                        oeb_r   <= 1'b1;
                        row_r   <= (row_r == RW'(ROWS - 1)) ? '0 : row_r + RW'(1);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
`ifdef MATRIX_BRIGHTNESS_EN
                        if (cnt_r == on_len_s - CW'(1)) begin
                            oeb_r <= 1'b1;
                        end else begin
                            oeb_r <= oeb_r;
                        end
`else
                        oeb_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    le_r    <= 1'b0;
                    rsdi_r  <= 1'b0;
                    rclk_r  <= 1'b0;
                    oeb_r   <= 1'b1;
                end
            endcase
        end
    end

    assign LE          = le_r;
    assign RSDI        = rsdi_r;
    assign RCLK        = rclk_r;
    assign OEB         = oeb_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver (default parameters). The stimulus
// thread keeps a framebuffer model and, for every row LOAD it predicts from the
// row-period arithmetic, pushes the expected row; a negedge monitor rebuilds
// each row from the pins and pops/compares when OEB returns high.
module tb_matrix_scan_driver;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int CLKDIV = 4;
    localparam int HOLD   = 256;
    localparam int P      = 1 + (2 * COLS + 3) * CLKDIV + HOLD;   // 397
    localparam int FRAME  = ROWS * P;                            // 6352
    localparam int ON_LEN = HOLD;  // full-length enable (brightness 15 when enabled)

    typedef struct {
        logic [15:0] data;
        logic        is_row0;
    } exp_t;

    logic        clk;
    logic        wb_rst_i;
    logic        active;
    logic        fb_we;
    logic [3:0]  fb_row;
    logic [15:0] fb_data;
    logic        CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_start;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [3:0]  brightness = 4'd15;
`endif

    exp_t        exp_q[$];
    logic [15:0] fb_m [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run_cyc = 0;
    bit          running = 1'b0;
    int          rows_pushed = 0;
    int          rows_seen = 0;

    matrix_scan_driver dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .active      (active),
        .fb_we       (fb_we),
        .fb_row      (fb_row),
        .fb_data     (fb_data),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .CSDI        (CSDI),
        .CCLK        (CCLK),
        .LE          (LE),
        .RSDI        (RSDI),
        .RCLK        (RCLK),
        .OEB         (OEB),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_csdi"}, CSDI, 0);
        check({tag, "_cclk"}, CCLK, 0);
        check({tag, "_le"}, LE, 0);
        check({tag, "_rsdi"}, RSDI, 0);
        check({tag, "_rclk"}, RCLK, 0);
        check({tag, "_oeb"}, OEB, 1);
        check({tag, "_frame_start"}, frame_start, 0);
    endtask

    // End the current cycle: a LOAD cycle's row (after its writes) becomes an expectation.
    task automatic step();
        if (running && run_cyc >= 0 && (run_cyc % P) == 0) begin
            int r;
            r = (run_cyc / P) % ROWS;
            exp_q.push_back('{data: fb_m[r], is_row0: (r == 0)});
            rows_pushed++;
        end
        @(posedge clk);
        #1;
        fb_we = 1'b0;
        if (running) run_cyc++;
    endtask

    task automatic wr(input int r, input logic [15:0] d);
        fb_we   = 1'b1;
        fb_row  = r[3:0];
        fb_data = d;
        fb_m[r] = d;
    endtask

    // Monitor: rebuild each displayed row from the pins and score it.
    int          cyc_m = 0;
    logic [15:0] obs_data;
    int          nbits, nrclk, rsdi_n, le_n, oeb_n, fs_n;
    logic        rsdi_at_rclk, prev_cclk, prev_rclk, prev_oeb;
    int          last_rise, last_fs;
    bit          rise_valid, fs_valid;
    exp_t        e;

    always @(negedge clk) begin
        cyc_m++;
        if (wb_rst_i || !active) begin
            obs_data = 16'd0; nbits = 0; nrclk = 0; rsdi_n = 0; le_n = 0; oeb_n = 0; fs_n = 0;
            rsdi_at_rclk = 1'b0; prev_cclk = 1'b0; prev_rclk = 1'b0; prev_oeb = 1'b1;
            rise_valid = 1'b0; fs_valid = 1'b0;
        end else begin
            if (CCLK && !prev_cclk) begin
                obs_data = {obs_data[14:0], CSDI};
                nbits++;
            end
            if (RCLK && !prev_rclk) begin
                nrclk++;
                rsdi_at_rclk = RSDI;
            end
            if (RSDI) rsdi_n++;
            if (LE) le_n++;
            if (!OEB) oeb_n++;
            if (frame_start) begin
                fs_n++;
                if (fs_valid) check("frame_period", cyc_m - last_fs, FRAME);
                last_fs = cyc_m;
                fs_valid = 1'b1;
            end
            if (OEB && !prev_oeb) begin
                rows_seen++;
                if (rise_valid) check("row_period", cyc_m - last_rise, P);
                last_rise = cyc_m;
                rise_valid = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL row_unexpected: got row data %0h, expected no row", obs_data);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", obs_data, e.data);
                    check("cclk_edges", nbits, COLS);
                    check("rclk_pulses", nrclk, 1);
                    check("rsdi_at_rclk", rsdi_at_rclk, e.is_row0);
                    check("rsdi_cycles", rsdi_n, e.is_row0 ? 2 * CLKDIV : 0);
                    check("le_cycles", le_n, CLKDIV);
                    check("oeb_low_cycles", oeb_n, ON_LEN);
                    check("frame_start_pulses", fs_n, e.is_row0 ? 1 : 0);
                end
                obs_data = 16'd0; nbits = 0; nrclk = 0; rsdi_n = 0; le_n = 0; oeb_n = 0; fs_n = 0;
                rsdi_at_rclk = 1'b0;
            end
            prev_cclk = CCLK;
            prev_rclk = RCLK;
            prev_oeb  = OEB;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int r;
        wb_rst_i = 1'b1; active = 1'b0; fb_we = 1'b0; fb_row = 4'd0; fb_data = 16'd0;
        for (int i = 0; i < 16; i++) fb_m[i] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        wb_rst_i = 1'b0;
        step();

        // Preload the framebuffer while idle; row 0 carries the edge-pixel pattern.
        for (int i = 0; i < ROWS; i++) begin
            wr(i, (i == 0) ? 16'h8001 : 16'($urandom()));
            step();
        end

        // Two full frames with random writes, a mid-SHIFT write to row 3 and
        // writes landing exactly on a row's LOAD cycle.
        active = 1'b1; running = 1'b1; run_cyc = -1;
        step();
        while (run_cyc < 2 * FRAME + P + 50) begin
            if (run_cyc == 3 * P + 20) wr(3, 16'hFFFF);
            else if (run_cyc == 5 * P || run_cyc == FRAME + 9 * P) wr((run_cyc / P) % ROWS, 16'($urandom()));
            else if (run_cyc > 0 && $urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 15);
                if (r == 3) r = 4;
                wr(r, 16'($urandom()));
            end
            step();
        end

        // Drop active mid-SHIFT of row 1: everything idles next cycle.
        active = 1'b0; running = 1'b0; exp_q.delete();
        rows_pushed = rows_seen;
        step();
        check_idle("active_drop");
        repeat (5) step();
        active = 1'b1; running = 1'b1; run_cyc = -1;
        step();
        check("fs_at_load", frame_start, 0);
        step();
        check("fs_two_cycles_after_active", frame_start, 1);
        while (run_cyc < P + 241) step();

        // Reset mid-DISPLAY of row 1: OEB must rise without a clock edge.
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("oeb_async_reset", OEB, 1);
        check("le_async_reset", LE, 0);
        exp_q.delete();
        rows_pushed = rows_seen;
        running = 1'b0;
        for (int i = 0; i < 16; i++) fb_m[i] = 16'd0;
        repeat (2) step();
        wb_rst_i = 1'b0; running = 1'b1; run_cyc = -1;
        while (run_cyc < 3 * P) step();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("rows_seen", rows_seen, rows_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL have parameter ROWS, default 16: matrix rows, 2..64.
REQ-002 SHALL have parameter COLS, default 16: matrix columns, 2..64.
REQ-003 SHALL have parameter CLKDIV, default 4: wb_clk_i cycles per shift-clock half-period, >=1.
REQ-004 SHALL have parameter ROW_HOLD, default 256: cycles each row is displayed, a multiple of 16.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port active, input, 1 bit: enable; low holds the block idle.
REQ-008 SHALL have port fb_we, input, 1 bit: framebuffer row write strobe.
REQ-009 SHALL have port fb_row, input, $clog2(ROWS) bits: row address being written.
REQ-010 SHALL have port fb_data, input, COLS bits: row pixels; bit COLS-1 is the leftmost pixel.
REQ-011 SHALL have outputs CSDI, CCLK, LE, RSDI, RCLK and OEB, 1 bit each: column data, column clock, column latch, row data, row clock, and active-low output enable.
REQ-012 SHALL have output frame_start, 1 bit: one-cycle pulse at the start of row 0.

Function
REQ-013 SHALL hold a ROWS x COLS framebuffer; fb_we writes fb_data to fb_row on the clock edge; fb_row >= ROWS is ignored.
REQ-014 SHALL use the FSM states IDLE, LOAD, SHIFT, ROWCLK, LATCH and DISPLAY.
REQ-015 SHALL move IDLE->LOAD when active=1; LOAD lasts 1 cycle, captures framebuffer[row] into the shift register and pulses frame_start when row==0.
REQ-016 SHALL, in SHIFT, emit COLS bits MSB first: CSDI valid with CCLK low for CLKDIV cycles, then CCLK high for CLKDIV cycles.
REQ-017 SHALL, in ROWCLK, drive RSDI=(row==0) for 2*CLKDIV cycles, with RCLK low for the first CLKDIV cycles and high for the second CLKDIV cycles (walking one-hot row select).
REQ-018 SHALL, in LATCH, drive LE high for CLKDIV cycles; CCLK and RCLK return low.
REQ-019 SHALL keep OEB=1 in every state except DISPLAY; DISPLAY lasts ROW_HOLD cycles, then row increments, wraps ROWS-1->0, and the FSM returns to LOAD.
REQ-020 SHALL have a row period of 1+(2*COLS+3)*CLKDIV+ROW_HOLD cycles (defaults: 397).
REQ-021 SHALL make a framebuffer write to the row currently shifting or displaying visible only at that row's next LOAD; a write in the same cycle as LOAD of that row is captured (write-first).
REQ-022 SHALL, when active falls in any state, enter IDLE next cycle with all outputs at reset values; row resets to 0; the framebuffer is retained.

Reset
REQ-023 SHALL asynchronously clear on wb_rst_i: FSM=IDLE, row=0, counters=0, CSDI=CCLK=LE=RSDI=RCLK=frame_start=0, OEB=1; framebuffer cleared to 0.
REQ-024 SHALL, on reset mid-operation, apply REQ-023 immediately, and resume with LOAD of row 0 on the first cycle after deassertion with active=1.

Configuration
REQ-025 SHALL, with MATRIX_BRIGHTNESS_EN defined, add input brightness[3:0], sampled on DISPLAY entry; OEB is then low for the first (brightness+1)*ROW_HOLD/16 cycles of DISPLAY and high for the remainder; DISPLAY length is unchanged.
REQ-026 SHALL, without MATRIX_BRIGHTNESS_EN, omit the brightness port and keep OEB low for the whole of DISPLAY.

Structure
REQ-027 SHALL place the FSM state enum and phase-length localparams in package matrix_pkg.
REQ-028 SHALL implement the serialiser (load, CLKDIV pacing, MSB-first CSDI/CCLK) as sub-module matrix_col_shifter, instantiated once.

Verification
REQ-029 SHALL be verified by this scenario: with defaults, write row 0 = 16'h8001 and release reset with active=1 -> CSDI is 1,0x14,1 on 16 CCLK rising edges, one RCLK pulse with RSDI=1, LE high for 4 cycles, OEB low for 256 cycles.
REQ-030 SHALL be verified by this scenario: free-run with defaults -> frame_start pulses every 16*397=6352 cycles; RSDI=1 only during the row 0 RCLK.
REQ-031 SHALL be verified by this scenario: write row 3 = 16'hFFFF during row 3's SHIFT -> the old data is shifted; 16'hFFFF appears in the next frame.
REQ-032 SHALL be verified by this scenario: drop active mid-SHIFT -> all outputs are at reset values next cycle with OEB=1; on raising active, frame_start pulses 2 cycles later.
REQ-033 SHALL be verified by this scenario: assert wb_rst_i mid-DISPLAY -> OEB=1 with no clock edge, and the framebuffer reads as all zero.
REQ-034 SHALL be verified by this scenario: with MATRIX_BRIGHTNESS_EN and brightness=3 -> OEB is low 64 cycles then high 192 cycles per row; with brightness=15 -> low all 256 cycles.
